hazard_fwd_unit: RTL and testbench
==================================

HAZARD_FWD_UNIT -- requirements
Module: hazard_fwd_unit

Interface
REQ-001 Parameter: none; all widths fixed (5-bit register indices, 2-bit selects, 16-bit counter).
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 id_rs, id_rt  in  5 each  source register indices of the instruction in ID.
REQ-005 id_dst  in  5  destination index of the ID instruction, after RegDst mux.
REQ-006 id_regwrite, id_memread, id_uses_rt, id_branch  in  1 each  ID-stage control bits.
REQ-007 alu_zero  in  1  zero flag from the ALU for the EX-stage instruction.
REQ-008 c_data1_src, c_data2_src  out  2 each  ALU operand selects.
- 00: ID/EX value.
- 10: EX/MEM result.
- 01: MEM/WB result.
REQ-009 stall  out  1  hold PC and IF/ID, and insert a bubble into ID/EX.
REQ-010 flush  out  1  squash IF/ID and ID/EX: the branch in EX is taken.
REQ-011 stall_cnt  out  16  count of stall cycles.

Function
REQ-012 The unit shall keep a shadow pipeline of the control bits below, each stage register advancing on every rising clk edge.
- EX: rs, rt, dst, regwrite, memread, uses_rt, branch.
- MEM: dst, regwrite.
- WB: dst, regwrite.
REQ-013 On a rising edge with stall=1 or flush=1, the EX shadow stage shall load a bubble (all fields 0); MEM and WB shall still advance.
REQ-014 Forwarding for c_data1_src shall be combinational from shadow state, evaluated in priority order:
- 10 if mem_regwrite, mem_dst!=0 and mem_dst==ex_rs;
- else 01 if wb_regwrite, wb_dst!=0 and wb_dst==ex_rs;
- else 00.
REQ-015 c_data2_src shall follow the same rule using ex_rt, and shall be 00 when ex_uses_rt=0.
REQ-016 Register 0 shall never be forwarded or cause a stall.
REQ-017 Load-use stall: stall shall be 1 (combinational) when all of the following hold:
- ex_memread=1 and ex_dst!=0;
- ex_dst==id_rs, or (id_uses_rt and ex_dst==id_rt).
REQ-018 A load-use stall shall last exactly one cycle, because the bubble clears ex_memread.
REQ-019 flush shall equal ex_branch & alu_zero (combinational).
REQ-020 When flush=1, stall shall be forced to 0; flush has priority.
REQ-021 stall_cnt shall increment by 1 on each rising edge with stall=1 and shall saturate at 16'hFFFF.
REQ-022 Selects 11 shall never be driven.

Reset
REQ-023 While rst=1, all shadow stages and stall_cnt shall be 0, immediately and without waiting for clk.
REQ-024 Consequently, during reset the outputs shall be c_data1_src=c_data2_src=00, stall=0 and flush=0.
REQ-025 Reset asserted mid-stall shall clear the stall; counting shall resume from 0 after rst falls.

Configuration
REQ-026 Macro FWD_EN compiled in: forwarding behaves per REQ-014..REQ-018.
REQ-027 Macro FWD_EN absent: selects shall be tied to 00, and stall shall assert on any of the following:
- (ex_regwrite and ex_dst!=0) matching id_rs or id_rt-if-used;
- (mem_regwrite and mem_dst!=0) matching id_rs or id_rt-if-used.
REQ-028 With FWD_EN absent, the register file is write-before-read, so the WB stage causes no stall.
REQ-029 REQ-013, REQ-019..REQ-021 apply in both builds.

Verification
REQ-030 add $8,$1,$2 followed by sub $9,$8,$3 -> when sub is in EX, c_data1_src=10, c_data2_src=00, stall never asserts.
REQ-031 add $8 ; nop ; or $9,$3,$8 -> when or is in EX, c_data2_src=01.
REQ-032 Same dst in MEM and WB (add $8 ; add $8 ; and $9,$8,$8) -> both selects=10, since EX/MEM has priority.
REQ-033 lw $8,0($1) followed by add $9,$8,$2 -> stall=1 for exactly one cycle, stall_cnt goes 0->1, then c_data1_src=01.
REQ-034 beq in EX with alu_zero=1 while a load-use condition is also present -> flush=1, stall=0, EX bubble on the next edge.
REQ-035 Write to $0 followed by a reader of $0 -> selects 00, no stall; rst pulsed mid-stall -> outputs 0 asynchronously, stall_cnt=0.

Source files
------------

// File: rtl/hazard_fwd_unit.sv
// Hazard detection and forwarding unit for a 5-stage MIPS-style pipeline.
// Define FWD_EN to enable EX/MEM and MEM/WB forwarding; otherwise RAW hazards stall.
module hazard_fwd_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic [4:0]  id_dst,
  input  logic        id_regwrite,
  input  logic        id_memread,
  input  logic        id_uses_rt,
  input  logic        id_branch,
  input  logic        alu_zero,
  output logic [1:0]  c_data1_src,
  output logic [1:0]  c_data2_src,
  output logic        stall,
  output logic        flush,
  output logic [15:0] stall_cnt
);

  logic [4:0]  ex_rs_q, ex_rs_d;
  logic [4:0]  ex_rt_q, ex_rt_d;
  logic [4:0]  ex_dst_q, ex_dst_d;
  logic        ex_regwrite_q, ex_regwrite_d;
  logic        ex_memread_q, ex_memread_d;
  logic        ex_uses_rt_q, ex_uses_rt_d;
  logic        ex_branch_q, ex_branch_d;
  logic [4:0]  mem_dst_q, mem_dst_d;
  logic        mem_regwrite_q, mem_regwrite_d;
  logic [4:0]  wb_dst_q, wb_dst_d;
  logic        wb_regwrite_q, wb_regwrite_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic        hazard;
  logic        bubble;

  // True when a writer of dst (never $0) feeds a source of the ID instruction.
  function automatic logic id_reads(input logic wr, input logic [4:0] dst);
    return wr && (dst != 5'd0) &&
           ((dst == id_rs) || (id_uses_rt && (dst == id_rt)));
  endfunction

`ifdef FWD_EN
  function automatic logic [1:0] fwd_sel(input logic [4:0] src);
    if (mem_regwrite_q && (mem_dst_q != 5'd0) && (mem_dst_q == src))
      return 2'b10;
    else if (wb_regwrite_q && (wb_dst_q != 5'd0) && (wb_dst_q == src))
      return 2'b01;
    else
      return 2'b00;
  endfunction
`else
  logic unused_ex_bits;
  assign unused_ex_bits = ^{ex_rs_q, ex_rt_q, ex_uses_rt_q, ex_memread_q,
                            wb_dst_q, wb_regwrite_q};
`endif

  always_comb begin
    c_data1_src = 2'b00;
    c_data2_src = 2'b00;
    hazard      = 1'b0;
`ifdef FWD_EN
    c_data1_src = fwd_sel(ex_rs_q);
    c_data2_src = ex_uses_rt_q ? fwd_sel(ex_rt_q) : 2'b00;
    hazard      = id_reads(ex_memread_q, ex_dst_q);
`else
    // WB needs no check: the register file writes before it reads.
    hazard      = id_reads(ex_regwrite_q, ex_dst_q) ||
                  id_reads(mem_regwrite_q, mem_dst_q);
`endif
    flush = ex_branch_q & alu_zero;
    stall = hazard & ~flush;
  end

  always_comb begin
    bubble         = stall | flush;
    ex_rs_d        = bubble ? 5'd0 : id_rs;
    ex_rt_d        = bubble ? 5'd0 : id_rt;
    ex_dst_d       = bubble ? 5'd0 : id_dst;
    ex_regwrite_d  = bubble ? 1'b0 : id_regwrite;
    ex_memread_d   = bubble ? 1'b0 : id_memread;
    ex_uses_rt_d   = bubble ? 1'b0 : id_uses_rt;
    ex_branch_d    = bubble ? 1'b0 : id_branch;
    mem_dst_d      = ex_dst_q;
    mem_regwrite_d = ex_regwrite_q;
    wb_dst_d       = mem_dst_q;
    wb_regwrite_d  = mem_regwrite_q;
    stall_cnt_d    = stall_cnt_q;
    if (stall && (stall_cnt_q != 16'hFFFF))
      stall_cnt_d = stall_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_rs_q        <= 5'd0;
      ex_rt_q        <= 5'd0;
      ex_dst_q       <= 5'd0;
      ex_regwrite_q  <= 1'b0;
      ex_memread_q   <= 1'b0;
      ex_uses_rt_q   <= 1'b0;
      ex_branch_q    <= 1'b0;
      mem_dst_q      <= 5'd0;
      mem_regwrite_q <= 1'b0;
      wb_dst_q       <= 5'd0;
      wb_regwrite_q  <= 1'b0;
      stall_cnt_q    <= 16'd0;
    end else begin
      ex_rs_q        <= ex_rs_d;
      ex_rt_q        <= ex_rt_d;
      ex_dst_q       <= ex_dst_d;
      ex_regwrite_q  <= ex_regwrite_d;
      ex_memread_q   <= ex_memread_d;
      ex_uses_rt_q   <= ex_uses_rt_d;
      ex_branch_q    <= ex_branch_d;
      mem_dst_q      <= mem_dst_d;
      mem_regwrite_q <= mem_regwrite_d;
      wb_dst_q       <= wb_dst_d;
      wb_regwrite_q  <= wb_regwrite_d;
      stall_cnt_q    <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Scoreboard bench for hazard_fwd_unit: directed pipeline scenarios then random
// instruction streams, predicted by an instruction-level model of the pipeline.
module tb_hazard_fwd_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  id_rs = '0, id_rt = '0, id_dst = '0;
  logic        id_regwrite = 1'b0, id_memread = 1'b0, id_uses_rt = 1'b0, id_branch = 1'b0;
  logic        alu_zero = 1'b0;
  logic [1:0]  c_data1_src, c_data2_src;
  logic        stall, flush;
  logic [15:0] stall_cnt;

  hazard_fwd_unit dut (
    .clk(clk), .rst(rst),
    .id_rs(id_rs), .id_rt(id_rt), .id_dst(id_dst),
    .id_regwrite(id_regwrite), .id_memread(id_memread),
    .id_uses_rt(id_uses_rt), .id_branch(id_branch),
    .alu_zero(alu_zero),
    .c_data1_src(c_data1_src), .c_data2_src(c_data2_src),
    .stall(stall), .flush(flush), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int rs, rt, dst;
    bit rw, mr, ur, br;
  } instr_t;

  typedef struct {
    int sel1, sel2, stall, flush, cnt;
  } exp_t;

  localparam instr_t NOP = '{0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0};

  // Reference model: the instructions occupying EX, MEM and WB, plus a stall total.
  instr_t exI = NOP, memI = NOP, wbI = NOP;
  int     cntM = 0;
  exp_t   expq[$];
  int     checks = 0;
  int     errors = 0;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Where the EX instruction should get a source from: the nearest older writer.
  function automatic int srcFrom(input int r);
    if (r == 0) return 0;
    if (memI.rw && memI.dst == r) return 2;
    if (wbI.rw && wbI.dst == r) return 1;
    return 0;
  endfunction

  function automatic bit feedsId(input instr_t w, input instr_t id);
    return w.rw && w.dst != 0 && (w.dst == id.rs || (id.ur && w.dst == id.rt));
  endfunction

  function automatic bit needStall(input instr_t id);
`ifdef FWD_EN
    return exI.mr && feedsId(exI, id);
`else
    return feedsId(exI, id) || feedsId(memI, id);
`endif
  endfunction

  task automatic applyStimulus(input int rs, input int rt, input int dst,
                               input bit rw, input bit mr, input bit ur, input bit br,
                               input bit zero, input bit r, input bit midReset);
    instr_t id;
    exp_t   e;
    bit     fl, st;
    id = '{rs, rt, dst, rw, mr, ur, br};
    @(negedge clk);
    rst = r;
    id_rs = 5'(rs); id_rt = 5'(rt); id_dst = 5'(dst);
    id_regwrite = rw; id_memread = mr; id_uses_rt = ur; id_branch = br;
    alu_zero = zero;
    fl = !r && exI.br && zero;
    st = !r && !fl && needStall(id);
    e.flush = fl;
    e.stall = st;
    e.cnt   = r ? 0 : cntM;
`ifdef FWD_EN
    e.sel1 = r ? 0 : srcFrom(exI.rs);
    e.sel2 = (r || !exI.ur) ? 0 : srcFrom(exI.rt);
`else
    e.sel1 = 0;
    e.sel2 = 0;
`endif
    expq.push_back(e);
    if (midReset) begin
      #4;
      rst = 1'b1;
      #1;
      checkOutput("async_rst_stall", int'(stall), 0);
      checkOutput("async_rst_flush", int'(flush), 0);
      checkOutput("async_rst_cnt", int'(stall_cnt), 0);
      checkOutput("async_rst_sel1", int'(c_data1_src), 0);
      checkOutput("async_rst_sel2", int'(c_data2_src), 0);
    end
    @(posedge clk);
    if (rst) begin
      exI = NOP; memI = NOP; wbI = NOP; cntM = 0;
    end else begin
      if (st && cntM < 65535) cntM++;
      wbI  = memI;
      memI = exI;
      exI  = (st || fl) ? NOP : id;
    end
  endtask

  task automatic nop(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Monitor: the unit presents a result every cycle; sample mid low phase.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (expq.size() > 0) begin
        e = expq.pop_front();
        checkOutput("c_data1_src", int'(c_data1_src), e.sel1);
        checkOutput("c_data2_src", int'(c_data2_src), e.sel2);
        checkOutput("stall", int'(stall), e.stall);
        checkOutput("flush", int'(flush), e.flush);
        checkOutput("stall_cnt", int'(stall_cnt), e.cnt);
      end
    end
  end

  initial begin
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    nop(1);
    // add $8,$1,$2 ; sub $9,$8,$3
    applyStimulus(1, 2, 8, 1, 0, 1, 0, 0, 0, 0);
    applyStimulus(8, 3, 9, 1, 0, 1, 0, 0, 0, 0);
    nop(3);
    // add $8 ; nop ; or $9,$3,$8
    applyStimulus(1, 2, 8, 1, 0, 1, 0, 0, 0, 0);
    nop(1);
    applyStimulus(3, 8, 9, 1, 0, 1, 0, 0, 0, 0);
    nop(3);
    // add $8 ; add $8 ; and $9,$8,$8
    applyStimulus(1, 2, 8, 1, 0, 1, 0, 0, 0, 0);
    applyStimulus(3, 4, 8, 1, 0, 1, 0, 0, 0, 0);
    applyStimulus(8, 8, 9, 1, 0, 1, 0, 0, 0, 0);
    nop(3);
    // lw $8,0($1) ; add $9,$8,$2 held in ID across the stall
    applyStimulus(1, 0, 8, 1, 1, 0, 0, 0, 0, 0);
    applyStimulus(8, 2, 9, 1, 0, 1, 0, 0, 0, 0);
    applyStimulus(8, 2, 9, 1, 0, 1, 0, 0, 0, 0);
    nop(3);
    // taken branch in EX while the ID instruction also reads a pending load
    applyStimulus(1, 2, 8, 0, 1, 1, 1, 0, 0, 0);
    applyStimulus(8, 8, 9, 1, 0, 1, 0, 1, 0, 0);
    nop(3);
    // writes to $0 then readers of $0
    applyStimulus(1, 2, 0, 1, 0, 1, 0, 0, 0, 0);
    applyStimulus(0, 0, 9, 1, 0, 1, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 1, 1, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 9, 1, 0, 1, 0, 0, 0, 0);
    nop(3);
    // reset pulsed in the middle of a load-use stall
    applyStimulus(1, 0, 8, 1, 1, 0, 0, 0, 0, 0);
    applyStimulus(8, 2, 9, 1, 0, 1, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    nop(1);
    applyStimulus(1, 0, 8, 1, 1, 0, 0, 0, 0, 0);
    applyStimulus(8, 2, 9, 1, 0, 1, 0, 0, 0, 0);
    nop(3);
    // random instruction streams over a small register set to provoke hazards
    for (int i = 0; i < 800; i++) begin
      applyStimulus($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                    ($urandom_range(0, 9) < 7), ($urandom_range(0, 3) == 0),
                    ($urandom_range(0, 9) < 6), ($urandom_range(0, 6) == 0),
                    $urandom_range(0, 1), ($urandom_range(0, 99) == 0), 0);
    end
    nop(2);
    repeat (2) @(negedge clk);
    checkOutput("queue_drained", expq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
